// File: rtl/bw_io_ddr_vref_ctl.sv
// DDR pad vref select controller: ramps the 3-bit select one code at a time toward a
// requested target, settling after each step, and acknowledges when the target is reached.
//
// state  | meaning
// IDLE   | waiting for sel_req; busy_q high marks the accept cycle (target latched)
// STEP   | move cur_sel one code toward tgt_q unless freeze is high
// SETTLE | count down the settle interval after a step
// ACK    | one-cycle sel_ack pulse, then back to IDLE
module bw_io_ddr_vref_ctl #(
  parameter int          SETTLE_W  = 8,
  parameter logic [2:0]  RESET_SEL = 3'd4
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                sel_req,
  input  logic [2:0]          sel_tgt,
  input  logic [SETTLE_W-1:0] settle_cyc,
  input  logic                freeze,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                sel_ack,
  output logic                busy,
  output logic [2:0]          cur_sel
);

  typedef enum logic [1:0] {IDLE, STEP, SETTLE, ACK} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cur_sel_q, cur_sel_d;
  logic [2:0]          tgt_q, tgt_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic [SETTLE_W-1:0] settle_load;

  // A zero settle interval still gives the analog side one cycle per step.
  assign settle_load = (settle_cyc == '0) ? SETTLE_W'(1) : settle_cyc;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      cur_sel_q <= RESET_SEL;
      tgt_q     <= RESET_SEL;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (busy_q) begin
          if (tgt_q == cur_sel_q) begin
            state_d = ACK;
            busy_d  = 1'b0;
            ack_d   = 1'b1;
          end else begin
            state_d = STEP;
          end
        end else if (sel_req) begin
          tgt_d  = sel_tgt;
          busy_d = 1'b1;
        end
      end
      STEP: begin
        if (!freeze) begin
          // tgt_q != cur_sel_q here, so the step never wraps past 0 or 7.
          cur_sel_d = (tgt_q > cur_sel_q) ? cur_sel_q + 3'd1 : cur_sel_q - 3'd1;
          cnt_d     = settle_load;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - SETTLE_W'(1);
        if (cnt_q == SETTLE_W'(1)) begin
          if (cur_sel_q == tgt_q) begin
            state_d = ACK;
            busy_d  = 1'b0;
            ack_d   = 1'b1;
          end else begin
            state_d = STEP;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign a       = cur_sel_q[2];
  assign b       = cur_sel_q[1];
  assign c       = cur_sel_q[0];
  assign cur_sel = cur_sel_q;
  assign sel_ack = ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bw_io_ddr_vref_ctl.sv
// Directed bench for bw_io_ddr_vref_ctl: reset, up/down ramps, same-target, freeze and
// reset-abort, with cycle positions worked out by hand.
module tb_bw_io_ddr_vref_ctl;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       sel_req;
  logic [2:0] sel_tgt;
  logic [7:0] settle_cyc;
  logic       freeze;
  logic       a, b, c, sel_ack, busy;
  logic [2:0] cur_sel;

  int n_vec = 0;
  int n_err = 0;

  bw_io_ddr_vref_ctl #(.SETTLE_W(8), .RESET_SEL(3'd4)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .sel_req    (sel_req),
    .sel_tgt    (sel_tgt),
    .settle_cyc (settle_cyc),
    .freeze     (freeze),
    .a          (a),
    .b          (b),
    .c          (c),
    .sel_ack    (sel_ack),
    .busy       (busy),
    .cur_sel    (cur_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle k is the clock period after the k-th rising edge following the request drive;
  // it is sampled on the falling edge. A change seen in cycle k happened on edge k.
  task automatic run_xact(input string tag, input logic [2:0] tgt, input logic [7:0] s,
                          input int frz_at, input int frz_len,
                          input int exp_busy, input int exp_ack, input int exp_steps,
                          input int exp_first, input int exp_last, input int exp_gap);
    int         busy_n = 0;
    int         ack_cyc = 0;
    int         steps = 0;
    int         first = 0;
    int         last = 0;
    int         bad_gap = 0;
    int         bad_step = 0;
    int         bad_abc = 0;
    int         post_ack = 0;
    int         post_busy = 0;
    logic [2:0] prev;
    logic [2:0] want;
    @(negedge clk);
    sel_tgt    = tgt;
    settle_cyc = s;
    sel_req    = 1'b1;
    prev       = cur_sel;
    for (int k = 1; k <= 80 && ack_cyc == 0; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if ({a, b, c} !== cur_sel) bad_abc++;
      if (cur_sel !== prev) begin
        steps++;
        want = (tgt > prev) ? 3'(prev + 3'd1) : 3'(prev - 3'd1);
        if (cur_sel !== want) bad_step++;
        if (steps > 1 && (k - last) != exp_gap) bad_gap++;
        if (first == 0) first = k;
        last = k;
        prev = cur_sel;
      end
      if (sel_ack) begin
        ack_cyc = k;
        sel_req = 1'b0;
      end
      if (frz_len > 0 && k == frz_at) freeze = 1'b1;
      if (frz_len > 0 && k == frz_at + frz_len) freeze = 1'b0;
    end
    sel_req = 1'b0;
    freeze  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (sel_ack) post_ack++;
      if (busy) post_busy++;
      if (cur_sel !== prev) bad_step++;
    end
    chk({tag, "_ack_cyc"}, ack_cyc, exp_ack);
    chk({tag, "_busy_cyc"}, busy_n, exp_busy);
    chk({tag, "_steps"}, steps, exp_steps);
    chk({tag, "_first_step"}, first, exp_first);
    chk({tag, "_last_step"}, last, exp_last);
    chk({tag, "_gap_errs"}, bad_gap, 0);
    chk({tag, "_step_errs"}, bad_step, 0);
    chk({tag, "_abc_errs"}, bad_abc, 0);
    chk({tag, "_post_ack"}, post_ack, 0);
    chk({tag, "_post_busy"}, post_busy, 0);
    chk({tag, "_final_sel"}, cur_sel, tgt);
  endtask

  initial begin
    int acks;
    int reach;
    rst_l      = 1'b0;
    sel_req    = 1'b0;
    sel_tgt    = 3'd0;
    settle_cyc = 8'd0;
    freeze     = 1'b0;

    #12;
    chk("rst_sel", cur_sel, 3'd4);
    chk("rst_abc", {a, b, c}, 3'b100);
    chk("rst_busy", busy, 0);
    chk("rst_ack", sel_ack, 0);
    @(negedge clk);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_sel", cur_sel, 3'd4);
    chk("idle_busy", busy, 0);

    // Same target, freeze high in IDLE must not block the accept.
    freeze = 1'b1;
    run_xact("same", 3'd4, 8'd3, 0, 0, 1, 2, 0, 0, 0, 0);

    // 4 -> 7, settle 3: steps on cycles 3, 7, 11; ack cycle 14; busy cycles 1..13.
    run_xact("up", 3'd7, 8'd3, 0, 0, 13, 14, 3, 3, 11, 4);

    @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    // 4 -> 0, settle 0 (treated as 1): steps on cycles 3, 5, 7, 9; ack cycle 10.
    run_xact("down", 3'd0, 8'd0, 0, 0, 9, 10, 4, 3, 9, 2);

    // 0 -> 7 with settle 2, aborted by reset once cur_sel reaches 3 (cycle 9).
    acks  = 0;
    reach = 0;
    @(negedge clk);
    sel_tgt    = 3'd7;
    settle_cyc = 8'd2;
    sel_req    = 1'b1;
    for (int k = 1; k <= 40 && reach == 0; k++) begin
      @(negedge clk);
      if (sel_ack) acks++;
      if (cur_sel == 3'd3) reach = k;
    end
    chk("abort_reach_cyc", reach, 9);
    #2;
    rst_l   = 1'b0;
    sel_req = 1'b0;
    #1;
    chk("abort_sel", cur_sel, 3'd4);
    chk("abort_busy", busy, 0);
    chk("abort_ack", sel_ack, 0);
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sel_ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_hold_sel", cur_sel, 3'd4);

    // 4 -> 6, settle 2, freeze seen on edges 3..12 while in STEP: first step moves
    // to cycle 13, second on 16, ack on 18, busy cycles 1..17.
    run_xact("freeze", 3'd6, 8'd2, 2, 10, 17, 18, 2, 13, 16, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
